// File: rtl/veda_regfile.sv
// veda_regfile: general-purpose scratch store for the VEDA memory subsystem.
// A DEPTH x DATA_W array with one byte-enabled write port and one read port.
// The read port either echoes the write data (scribble, i_mode=0) or returns
// the stored word (interpret, i_mode=1). Reads go through a two-stage
// registered pipeline with write-first bypass. A sequential soft-clear engine
// zeroes the array one entry per cycle without needing a reset.
//
// Ports:
//   clk, reset    clock (rising edge) / async active-high reset
//   i_wr_en       write request        i_wr_addr / i_wr_data / i_wr_be
//   i_rd_en       read request         i_rd_addr, i_mode (0 echo, 1 storage)
//   i_clr_req     start soft clear
//   o_rd_data     registered read result (holds when o_rd_valid=0)
//   o_rd_valid    one-cycle strobe: o_rd_data is new this cycle
//   o_busy        soft clear in progress; requests are discarded
//   o_drop        one-cycle pulse: a request was discarded while busy
module veda_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic [DATA_W/8-1:0]   i_wr_be,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  input  logic                  i_mode,
  input  logic                  i_clr_req,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_drop
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_s1_data;
  logic [2:1]          r_vld_pipe;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_drop;

  logic                w_busy, w_wr_acc, w_rd_acc, w_byp_hit;
  logic [DATA_W-1:0]   w_wr_old, w_wr_merged, w_rd_old, w_rd_byp, w_s1_nxt;

  assign w_busy    = (r_state == CLEAR);
  assign w_wr_acc  = i_wr_en & ~w_busy;
  assign w_rd_acc  = i_rd_en & ~w_busy;
  assign w_byp_hit = w_wr_acc & (i_wr_addr == i_rd_addr);
  assign w_wr_old  = r_mem[i_wr_addr];
  assign w_rd_old  = r_mem[i_rd_addr];

  // Per-lane merge for the write port and for the write-first read bypass.
  always_comb begin
    w_wr_merged = w_wr_old;
    w_rd_byp    = w_rd_old;
    for (int i = 0; i < BE_W; i++) begin
      if (i_wr_be[i]) w_wr_merged[8*i +: 8] = i_wr_data[8*i +: 8];
      if (i_wr_be[i] && w_byp_hit) w_rd_byp[8*i +: 8] = i_wr_data[8*i +: 8];
    end
  end

  // Scribble echoes the full write word regardless of byte enables.
  assign w_s1_nxt = i_mode ? w_rd_byp : i_wr_data;

  // Storage: clear engine and write port never overlap since writes are
  // only accepted outside CLEAR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_busy) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[i_wr_addr] <= w_wr_merged;
    end
  end

  // Read pipeline: stage 1 captures, stage 2 presents with the valid strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_s1_data  <= '0;
      r_rd_data  <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], w_rd_acc};
      if (w_rd_acc)      r_s1_data <= w_s1_nxt;
      if (r_vld_pipe[1]) r_rd_data <= r_s1_data;
      r_drop <= w_busy & (i_wr_en | i_rd_en);
    end
  end

  // Clear FSM: state register and pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (!w_busy && i_clr_req) r_ptr <= '0;
      else if (w_busy)          r_ptr <= r_ptr + ADDR_W'(1); // wraps to 0 on exit
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_clr_req) w_state_nxt = CLEAR;
      CLEAR:   if (r_ptr == {ADDR_W{1'b1}}) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_vld_pipe[2];
  assign o_busy     = w_busy;
  assign o_drop     = r_drop;
endmodule
